// File: rtl/branch_sequencer_pkg.sv
// Shared encodings for the branch sequencer: ops, condition selects and FSM states.
package branch_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_JMP  = 3'b001,
    OP_CALL = 3'b010,
    OP_RET  = 3'b011,
    OP_HALT = 3'b100
  } op_t;

  typedef enum logic [2:0] {
    CND_AL = 3'b000,
    CND_Z  = 3'b001,
    CND_NZ = 3'b010,
    CND_C  = 3'b011,
    CND_NC = 3'b100,
    CND_N  = 3'b101,
    CND_P  = 3'b110,
    CND_NP = 3'b111
  } cond_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. The caller gates push/pop against full/empty; contents are not reset.
module ret_stack #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] din,
  output logic [ADDR_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [DW-1:0]         depth
);

  localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] mem [0:(1 << IW) - 1];
  logic [IW-1:0]         top_idx;

  assign top_idx = IW'(depth - DW'(1));
  assign dout    = mem[top_idx];
  assign full    = (depth == DW'(STACK_DEPTH));
  assign empty   = (depth == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
    end else if (push && !full) begin
      mem[IW'(depth)] <= din;
      depth           <= depth + DW'(1);
    end else if (pop && !empty) begin
      depth <= depth - DW'(1);
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Program-counter sequencer: resolves conditional JMP/CALL/RET from ALU flags, with RUN/HALT/FAULT FSM.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic [2:0]                           op,
  input  logic [2:0]                           cond,
  input  logic [ADDR_WIDTH-1:0]                target,
  input  logic                                 C,
  input  logic                                 N,
  input  logic                                 P,
  input  logic                                 Z,
  output logic [ADDR_WIDTH-1:0]                pc,
  output logic                                 taken,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     depth,
  output logic                                 halted,
  output logic                                 fault
);

  state_t                state;
  logic                  cond_true;
  logic                  advance;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] ret_addr;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      CND_AL:  cond_true = 1'b1;
      CND_Z:   cond_true = Z;
      CND_NZ:  cond_true = !Z;
      CND_C:   cond_true = C;
      CND_NC:  cond_true = !C;
      CND_N:   cond_true = N;
      CND_P:   cond_true = P;
      CND_NP:  cond_true = !P;
      default: cond_true = 1'b0;
    endcase
  end

  assign pc_inc  = pc + ADDR_WIDTH'(1);
  assign advance = (state == ST_RUN) && en;
  // Stack only moves on legal, condition-true CALL/RET; overflow/underflow leave it untouched.
  assign push    = advance && (op == OP_CALL) && cond_true && !full;
  assign pop     = advance && (op == OP_RET)  && cond_true && !empty;

  ret_stack #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (ret_addr),
    .full  (full),
    .empty (empty),
    .depth (depth)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      taken  <= 1'b0;
      state  <= ST_RUN;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      taken <= 1'b0;
      if (advance) begin
        case (op)
          OP_JMP: begin
            if (cond_true) begin
              pc    <= target;
              taken <= 1'b1;
            end else begin
              pc <= pc_inc;
            end
          end
          OP_CALL: begin
            if (!cond_true) begin
              pc <= pc_inc;
            end else if (full) begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end else begin
              pc    <= target;
              taken <= 1'b1;
            end
          end
          OP_RET: begin
            if (!cond_true) begin
              pc <= pc_inc;
            end else if (empty) begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end else begin
              pc    <= ret_addr;
              taken <= 1'b1;
            end
          end
          OP_HALT: begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end
          default: pc <= pc_inc;
        endcase
      end
    end
  end

endmodule
